key_schedule_seq: RTL
=====================

Name: key_schedule_seq

Overview:
- Iterative, word-serial AES key schedule generator for AES-128, AES-192 and AES-256, selected at run time.
- Produces one 32-bit schedule word per cycle and emits each 128-bit round key (rounds 0..Nr) over a valid/ready handshake.
- Sits between the key-load interface and the round datapath, replacing the per-round combinational expansion stage. The cipher consumes round keys in order at its own pace.

Parameters:
- BYTE, 8, byte width; only 8 supported
- WORD, 32, schedule word width; only 32 supported
- SENTENCE, 128, round key width; only 128 supported
- KEY_MAX, 256, width of key input; only 256 supported

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; loads key_In and key_Size when idle
- key_Size  in  2  00=AES-128 (Nk=4,Nr=10), 01=AES-192 (Nk=6,Nr=12), 10=AES-256 (Nk=8,Nr=14), 11 reserved
- key_In  in  KEY_MAX  cipher key, MSB-aligned: word w0 = key_In[255:224]; unused LSBs ignored
- busy  out  1  high from accepted start until last round key accepted
- round_Key_Out  out  SENTENCE  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs
- round_Number_Out  out  4  r of round_Key_Out
- key_Valid  out  1  round_Key_Out valid
- key_Ready  in  1  consumer accepts when key_Valid & key_Ready
- last  out  1  high with key_Valid when r == Nr

Behaviour:
- Reset: busy, key_Valid and last = 0; round_Key_Out = 0; round_Number_Out = 0; all counters, window and collector cleared.
- Reset acts immediately mid-run. The run is discarded and the block returns to IDLE.
- States:
  - IDLE: start=1 and key_Size != 11 → latch Nk/Nr and key words into an 8-word window, set word index i=0 and rcon=0x01, go to GEN, set busy. start with key_Size=11 is ignored.
  - GEN: produce w[i] each cycle unless stalled.
    - i < Nk: w[i] = key word i.
    - Otherwise temp = w[i-1], then:
      - i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, and rcon advances by xtime (0x80→0x1B).
      - Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
      - Then w[i] = w[i-Nk] ^ temp.
    - The window shifts in w[i]. i mod Nk is a separate counter; no divider is used.
    - Each word goes to a 4-word collector. When the 4th word is produced it transfers to round_Key_Out with key_Valid=1 and round_Number_Out=i/4, if the output register is empty or is being accepted this cycle.
  - STALL (within GEN): the collector is full and output is held (key_Valid & !key_Ready). No word is produced and i, rcon and window are frozen. Output is stable while key_Valid=1 and not accepted.
  - DRAIN: after w[4*Nr+3] transfers, generation stops. When round Nr is accepted, key_Valid and busy drop in the same edge's aftermath, and the state returns to IDLE.
- Latency without backpressure:
  - Round 0 key_Valid asserts 4 clocks after the start edge.
  - Then one round key every 4 clocks.
  - Total 4*(Nr+1) clocks: 44, 52 or 60.
- start while busy is ignored. key_In and key_Size are sampled only on the accepted start.
- key_Ready while key_Valid=0 has no effect.
- round_Number_Out and last change only when a new key is loaded.

Optional Feature:
- Macro KEY_SCHEDULE_ABORT_EN.
- With the macro: adds input port abort (1 bit). abort=1 in any state clears key_Valid, last and busy, and returns to IDLE on the next edge. Window and collector contents are don't-care. abort has priority over start in the same cycle.
- Without the macro: no abort port. A run can only be ended by completion or by rst_n.

Test Plan:
- AES-128 (FIPS-197 A.1): key 2b7e151628aed2a6abf7158809cf4f3c, key_Ready=1.
  - Round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with last=1.
  - key_Valid first asserts 4 clocks after start; busy drops after 44 clocks.
- AES-192: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Round 1 = 62f8ead2522c6b7bfe0c91f72402f5a5; round 12 = e98ba06f448c773c8ecc720401002202 with last=1.
- AES-256: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Round 2 = 9ba354118e6925afa51a8b5f2067fcde; round 14 = fe4890d1e6188d0b046df344706c631e.
- Backpressure: AES-128 with key_Ready toggled randomly and held low 20 cycles at round 3.
  - round_Key_Out and round_Number_Out stay stable while held low.
  - The same 11 keys arrive in order with none lost or duplicated.
- Control corners:
  - start with key_Size=11 → busy stays 0.
  - start mid-run → ignored; sequence unchanged.
  - rst_n low at round 5 → all outputs 0 immediately; a following start runs cleanly from round 0.
- With KEY_SCHEDULE_ABORT_EN: abort at round 7 together with start → IDLE and key_Valid=0. A new start then yields the correct round 0 key.

Source files
------------

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: word-serial AES-128/192/256 key schedule, one round key per valid/ready beat.
// Optional KEY_SCHEDULE_ABORT_EN adds an abort input that discards the current run.
module key_schedule_seq #(
  parameter int BYTE = 8,
  parameter int WORD = 32,
  parameter int SENTENCE = 128,
  parameter int KEY_MAX = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          key_Size,
  input  logic [KEY_MAX-1:0]  key_In,
  output logic                busy,
  output logic [SENTENCE-1:0] round_Key_Out,
  output logic [3:0]          round_Number_Out,
  output logic                key_Valid,
  input  logic                key_Ready,
`ifdef KEY_SCHEDULE_ABORT_EN
  input  logic                abort,
`endif
  output logic                last
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [BYTE-1:0] sub_byte(input logic [BYTE-1:0] x);
    return SBOX[{~x, 3'b000} +: BYTE];
  endfunction
  function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] x);
    return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
  endfunction
  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
  state_t state, state_nx;
  logic [WORD-1:0] win [8];
  logic [WORD-1:0] col [3];
  logic [WORD-1:0] prev, temp, w_new;
  logic [3:0] nk, nr, i_mod, nk_in;
  logic [5:0] i;
  logic [7:0] rcon;
  logic abrt, go, acc, stall, prod, xfer, fin, first;
`ifdef KEY_SCHEDULE_ABORT_EN
  assign abrt = abort;
`else
  assign abrt = 1'b0;
`endif
  assign busy = state != IDLE;
  always_comb begin
    nk_in = key_Size == 2'd0 ? 4'd4 : key_Size == 2'd1 ? 4'd6 : 4'd8;
    go = start && state == IDLE && key_Size != 2'b11 && !abrt;
    acc = key_Valid && key_Ready;
    stall = i[1:0] == 2'd3 && key_Valid && !key_Ready;
    prod = state == GEN && !stall && !abrt;
    xfer = prod && i[1:0] == 2'd3;
    fin = xfer && i == {nr, 2'b11};
    first = i < {2'b00, nk};
    prev = win[0];
    temp = i_mod == 4'd0 ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0}
         : (nk == 4'd8 && i_mod == 4'd4) ? sub_word(prev) : prev;
    // win[nk-1] holds w[i-Nk]; during the key phase it is rotated through unchanged
    w_new = first ? win[3'(nk - 4'd1)] : win[3'(nk - 4'd1)] ^ temp;
    state_nx = abrt ? IDLE : go ? GEN : fin ? DRAIN : (state == DRAIN && acc) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) win[j] <= '0;
      for (int j = 0; j < 3; j++) col[j] <= '0;
      nk <= '0;
      nr <= '0;
      i <= '0;
      i_mod <= '0;
      rcon <= '0;
      round_Key_Out <= '0;
      round_Number_Out <= '0;
      key_Valid <= 1'b0;
      last <= 1'b0;
    end else begin
      if (go) begin
        nk <= nk_in;
        nr <= nk_in + 4'd6;
        i <= '0;
        i_mod <= '0;
        rcon <= 8'h01;
        for (int j = 0; j < 8; j++) win[j] <= key_In[{3'(j - int'(nk_in)), 5'd0} +: WORD];
      end else if (prod) begin
        for (int j = 7; j > 0; j--) win[j] <= win[j-1];
        win[0] <= w_new;
        i <= i + 6'd1;
        i_mod <= i_mod == nk - 4'd1 ? 4'd0 : i_mod + 4'd1;
        if (!first && i_mod == 4'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (i[1:0] != 2'd3) col[i[1:0]] <= w_new;
      end
      if (xfer) begin
        round_Key_Out <= {col[0], col[1], col[2], w_new};
        round_Number_Out <= i[5:2];
        last <= i[5:2] == nr;
        key_Valid <= 1'b1;
      end else if (acc || abrt) key_Valid <= 1'b0;
      if (abrt) last <= 1'b0;
    end
  end
endmodule
